usb_io_buffer: RTL and testbench



---
 rtl/usb_io_buffer_if.sv | 40 ++++
 rtl/usb_io_buffer.sv | 137 +++++++++++++
 tb/tb_usb_io_buffer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/usb_io_buffer_if.sv
// ============================================================================
// usb_io_buffer_if : CPU register-bus and USB CDC stream signals of usb_io_buffer
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface usb_io_buffer_if;
    // CPU load/store path
    logic       sel_i;
    logic       read_i;
    logic       write_i;
    logic [1:0] addr_i;
    logic [7:0] data_i;
    logic [7:0] data_o;
    // TX stream towards USB CDC
    logic [7:0] in_data_o;
    logic       in_valid_o;
    logic       in_ready_i;
    // RX stream from USB CDC
    logic [7:0] out_data_i;
    logic       out_valid_i;
    logic       out_ready_o;
    // Interrupts
    logic       rx_irq_o;
    logic       tx_irq_o;

    modport slave (
        input  sel_i, read_i, write_i, addr_i, data_i,
        input  in_ready_i, out_data_i, out_valid_i,
        output data_o, in_data_o, in_valid_o, out_ready_o, rx_irq_o, tx_irq_o
    );

    modport master (
        output sel_i, read_i, write_i, addr_i, data_i,
        output in_ready_i, out_data_i, out_valid_i,
        input  data_o, in_data_o, in_valid_o, out_ready_o, rx_irq_o, tx_irq_o
    );
endinterface

`default_nettype wire

// File: rtl/usb_io_buffer.sv
// ============================================================================
// usb_io_buffer : memory-mapped TX/RX byte FIFOs between CPU and USB CDC streams
// Optional interrupts built when USB_IO_IRQ_EN is defined.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_io_buffer #(
    parameter int DEPTH = 16
) (
    input  wire logic      clk_i,
    input  wire logic      rst_i,
    usb_io_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [7:0]    r_tx_mem [DEPTH];
    logic [7:0]    r_rx_mem [DEPTH];
    logic [AW-1:0] r_tx_wr_ptr, r_tx_rd_ptr, r_rx_wr_ptr, r_rx_rd_ptr;
    logic [CW-1:0] r_tx_count, r_rx_count;
    logic          r_tx_ovf, r_rx_unf;
    logic [7:0]    r_data;

    logic          w_wr, w_rd, w_stat_wr;
    logic          w_tx_push_req, w_tx_full, w_tx_push, w_tx_pop;
    logic          w_rx_pop_req, w_rx_empty, w_rx_pop, w_rx_push;
    logic [CW-1:0] w_tx_count_nxt, w_rx_count_nxt;
    logic [7:0]    w_status, w_load_data;

    // Write wins over a simultaneous read
    assign w_wr      = bus.sel_i & bus.write_i;
    assign w_rd      = bus.sel_i & bus.read_i & ~bus.write_i;
    assign w_stat_wr = w_wr & (bus.addr_i == 2'd1);

    assign w_tx_full     = (r_tx_count == C_FULL);
    assign w_tx_push_req = w_wr & (bus.addr_i == 2'd0);
    assign w_tx_push     = w_tx_push_req & ~w_tx_full;
    assign w_tx_pop      = (r_tx_count != '0) & bus.in_ready_i;

    assign w_rx_empty    = (r_rx_count == '0);
    assign w_rx_pop_req  = w_rd & (bus.addr_i == 2'd0);
    assign w_rx_pop      = w_rx_pop_req & ~w_rx_empty;
    assign w_rx_push     = bus.out_valid_i & (r_rx_count != C_FULL);

    assign w_tx_count_nxt = r_tx_count + CW'(w_tx_push) - CW'(w_tx_pop);
    assign w_rx_count_nxt = r_rx_count + CW'(w_rx_push) - CW'(w_rx_pop);

    assign w_status = {4'b0000, r_tx_ovf, r_rx_unf, ~w_tx_full, ~w_rx_empty};

    always_comb begin
        w_load_data = 8'h00;
        if (w_rd) begin
            case (bus.addr_i)
                2'd0:    w_load_data = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rd_ptr];
                2'd1:    w_load_data = w_status;
                2'd2:    w_load_data = 8'(r_rx_count);
                default: w_load_data = 8'(r_tx_count);
            endcase
        end
    end

    assign bus.data_o      = r_data;
    assign bus.in_data_o   = r_tx_mem[r_tx_rd_ptr];
    assign bus.in_valid_o  = (r_tx_count != '0);
    assign bus.out_ready_o = (r_rx_count != C_FULL);

    // Storage needs no reset: pointers and counts define validity
    always_ff @(posedge clk_i) begin
        if (w_tx_push) r_tx_mem[r_tx_wr_ptr] <= bus.data_i;
        if (w_rx_push) r_rx_mem[r_rx_wr_ptr] <= bus.out_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_tx_count  <= '0;
            r_rx_count  <= '0;
            r_tx_ovf    <= 1'b0;
            r_rx_unf    <= 1'b0;
            r_data      <= 8'h00;
        end else begin
            if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + AW'(1);
            if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + AW'(1);
            if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + AW'(1);
            if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + AW'(1);
            r_tx_count <= w_tx_count_nxt;
            r_rx_count <= w_rx_count_nxt;
            r_data     <= w_load_data;

            // Set events take precedence over software clears
            if (w_tx_push_req & w_tx_full)
                r_tx_ovf <= 1'b1;
            else if (w_stat_wr & bus.data_i[3])
                r_tx_ovf <= 1'b0;

            if (w_rx_pop_req & w_rx_empty)
                r_rx_unf <= 1'b1;
            else if (w_stat_wr & bus.data_i[2])
                r_rx_unf <= 1'b0;
        end
    end

`ifdef USB_IO_IRQ_EN
    logic r_rx_irq, r_tx_irq, r_tx_arm;
    logic w_tx_irq_nxt;

    assign w_tx_irq_nxt = (w_tx_count_nxt == '0) & r_tx_arm;

    // Arm makes the TX-drained interrupt a single pulse per burst of pushes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_irq <= 1'b0;
            r_tx_irq <= 1'b0;
            r_tx_arm <= 1'b0;
        end else begin
            r_rx_irq <= (w_rx_count_nxt != '0);
            r_tx_irq <= w_tx_irq_nxt;
            r_tx_arm <= w_tx_push |
                        (r_tx_arm & ~w_tx_irq_nxt & ~(w_stat_wr & bus.data_i[4]));
        end
    end

    assign bus.rx_irq_o = r_rx_irq;
    assign bus.tx_irq_o = r_tx_irq;
`else
    assign bus.rx_irq_o = 1'b0;
    assign bus.tx_irq_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_usb_io_buffer.sv
// ============================================================================
// tb_usb_io_buffer : scoreboard bench for usb_io_buffer, queue-based reference model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_io_buffer;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    usb_io_buffer_if bus();

    usb_io_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: FIFOs as queues, flags as bits
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] load_q[$];
    bit         pend = 1'b0;
    bit         m_tx_ovf = 1'b0, m_rx_unf = 1'b0;
    bit         m_arm = 1'b0, m_rx_irq = 1'b0, m_tx_irq = 1'b0;
    bit         mon_en = 1'b0;

    bit         s_wr, s_rd, s_pushed, s_irq_new;
    int         s_txn, s_rxn;
    logic [7:0] s_exp;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: consumes the inputs each rising edge and predicts state after it
    always @(posedge clk) begin
        if (rst) begin
            tx_q.delete(); rx_q.delete(); load_q.delete();
            pend = 0; m_tx_ovf = 0; m_rx_unf = 0;
            m_arm = 0; m_rx_irq = 0; m_tx_irq = 0;
        end else begin
            s_wr  = bus.sel_i && bus.write_i;
            s_rd  = bus.sel_i && bus.read_i && !bus.write_i;
            s_txn = tx_q.size();
            s_rxn = rx_q.size();
            s_pushed = 0;
            pend = s_rd;
            if (s_rd) begin
                case (bus.addr_i)
                    2'd0: begin
                        if (s_rxn == 0) begin s_exp = 8'h00; end
                        else            begin s_exp = rx_q.pop_front(); end
                    end
                    2'd1: s_exp = {4'b0, m_tx_ovf, m_rx_unf, s_txn != DEPTH, s_rxn != 0};
                    2'd2: s_exp = 8'(s_rxn);
                    default: s_exp = 8'(s_txn);
                endcase
                load_q.push_back(s_exp);
            end
            if (s_txn != 0 && bus.in_ready_i) void'(tx_q.pop_front());
            if (s_wr && bus.addr_i == 2'd0 && s_txn != DEPTH) begin
                tx_q.push_back(bus.data_i);
                s_pushed = 1;
            end
            if (bus.out_valid_i && s_rxn != DEPTH) rx_q.push_back(bus.out_data_i);
            if (s_wr && bus.addr_i == 2'd1) begin
                if (bus.data_i[3]) m_tx_ovf = 0;
                if (bus.data_i[2]) m_rx_unf = 0;
            end
            if (s_wr && bus.addr_i == 2'd0 && s_txn == DEPTH) m_tx_ovf = 1;
            if (s_rd && bus.addr_i == 2'd0 && s_rxn == 0)     m_rx_unf = 1;
            m_rx_irq  = (rx_q.size() != 0);
            s_irq_new = (tx_q.size() == 0) && m_arm;
            m_tx_irq  = s_irq_new;
            m_arm = s_pushed || (m_arm && !s_irq_new &&
                                 !(s_wr && bus.addr_i == 2'd1 && bus.data_i[4]));
        end
    end

    // Monitor: compares DUT outputs mid-cycle against the model
    always @(negedge clk) begin
        if (mon_en) begin
            if (pend && load_q.size() != 0) chk("data_o", int'(bus.data_o), int'(load_q.pop_front()));
            else                            chk("data_o_idle", int'(bus.data_o), 0);
            chk("in_valid", int'(bus.in_valid_o), int'(tx_q.size() != 0));
            if (bus.in_valid_o && tx_q.size() != 0)
                chk("in_data", int'(bus.in_data_o), int'(tx_q[0]));
            chk("out_ready", int'(bus.out_ready_o), int'(rx_q.size() != DEPTH));
`ifdef USB_IO_IRQ_EN
            chk("rx_irq", int'(bus.rx_irq_o), int'(m_rx_irq));
            chk("tx_irq", int'(bus.tx_irq_o), int'(m_tx_irq));
`else
            chk("rx_irq", int'(bus.rx_irq_o), 0);
            chk("tx_irq", int'(bus.tx_irq_o), 0);
`endif
        end
    end

    task automatic cyc(input bit s, input bit r, input bit w,
                       input logic [1:0] a, input logic [7:0] d);
        bus.sel_i   = s;
        bus.read_i  = r;
        bus.write_i = w;
        bus.addr_i  = a;
        bus.data_i  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 2'd0, 8'h00);
    endtask

    initial begin
        bus.sel_i = 0; bus.read_i = 0; bus.write_i = 0;
        bus.addr_i = 0; bus.data_i = 0;
        bus.in_ready_i = 0; bus.out_valid_i = 0; bus.out_data_i = 0;
        @(posedge clk); #1;
        mon_en = 1;
        idle(1);
        rst = 0;

        // Reset state readback
        cyc(1, 1, 0, 2'd1, 8'h00);
        cyc(1, 1, 0, 2'd2, 8'h00);
        cyc(1, 1, 0, 2'd3, 8'h00);
        idle(1);

        // TX ordering with back-pressure then release
        bus.in_ready_i = 0;
        cyc(1, 0, 1, 2'd0, 8'h41);
        cyc(1, 0, 1, 2'd0, 8'h42);
        cyc(1, 0, 1, 2'd0, 8'h43);
        cyc(1, 1, 0, 2'd3, 8'h00);
        bus.in_ready_i = 1;
        idle(5);
        bus.in_ready_i = 0;

        // RX fill to full, 17th byte held off, then drain in order
        for (int i = 0; i < 17; i++) begin
            bus.out_valid_i = 1;
            bus.out_data_i  = 8'(i);
            idle(1);
        end
        idle(2);
        bus.out_valid_i = 0;
        for (int i = 0; i < 16; i++) cyc(1, 1, 0, 2'd0, 8'h00);

        // Underflow and flag clear
        cyc(1, 1, 0, 2'd0, 8'h00);
        cyc(1, 1, 0, 2'd1, 8'h00);
        cyc(1, 0, 1, 2'd1, 8'h04);
        cyc(1, 1, 0, 2'd1, 8'h00);

        // Read and write together: write wins
        cyc(1, 1, 1, 2'd0, 8'h5A);
        bus.in_ready_i = 1; idle(2); bus.in_ready_i = 0;

        // TX overflow with simultaneous USB pop
        for (int i = 0; i < 16; i++) cyc(1, 0, 1, 2'd0, 8'(8'h80 + i));
        bus.in_ready_i = 1;
        cyc(1, 0, 1, 2'd0, 8'hAA);
        bus.in_ready_i = 0;
        cyc(1, 1, 0, 2'd3, 8'h00);
        cyc(1, 1, 0, 2'd1, 8'h00);
        bus.in_ready_i = 1; idle(18); bus.in_ready_i = 0;
        cyc(1, 0, 1, 2'd1, 8'h1C);

        // Single-byte TX drain and single-byte RX arrival
        cyc(1, 0, 1, 2'd0, 8'h77);
        idle(2);
        bus.in_ready_i = 1; idle(4); bus.in_ready_i = 0;
        bus.out_valid_i = 1; bus.out_data_i = 8'h99; idle(1); bus.out_valid_i = 0;
        idle(2);
        cyc(1, 1, 0, 2'd0, 8'h00);
        idle(3);

        // Randomized traffic with varying stream pressure
        for (int ep = 0; ep < 8; ep++) begin
            int p_rdy, p_val, p_rd, p_wr;
            p_rdy = $urandom_range(5, 95);
            p_val = $urandom_range(5, 95);
            p_rd  = $urandom_range(5, 60);
            p_wr  = $urandom_range(5, 60);
            for (int i = 0; i < 500; i++) begin
                bit s, r, w;
                rst = ($urandom_range(0, 599) == 0);
                bus.in_ready_i  = ($urandom_range(0, 99) < p_rdy);
                bus.out_valid_i = ($urandom_range(0, 99) < p_val);
                bus.out_data_i  = 8'($urandom);
                s = ($urandom_range(0, 9) != 0);
                r = ($urandom_range(0, 99) < p_rd);
                w = ($urandom_range(0, 99) < p_wr);
                cyc(s, r, w, 2'($urandom_range(0, 3)) , 8'($urandom));
                rst = 0;
            end
        end
        bus.out_valid_i = 0;
        bus.in_ready_i  = 1;
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
